ov7670_init_sequencer: RTL and testbench

- Power-up and configuration sequencer for the OV7670 camera; sits inside the camera controller ahead of the SCCB master.
- Drives the camera power-down and reset pins with the required timing.
- Walks a register table in an external synchronous ROM and issues one SCCB write request per entry, retrying on NACK.
- Raises start_capture once the table completes, which releases the pixel capture path.

---
 rtl/ov7670_pkg.sv | 31 +++
 rtl/ov7670_timer.sv | 36 +++
 rtl/ov7670_init_sequencer.sv | 218 +++++++++++++++++++++
 tb/tb_ov7670_init_sequencer.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ov7670_pkg.sv
// Shared types and constants for the OV7670 power-up / register-load sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents:
//   state_t    - sequencer states
//   TABLE_END  - ROM word that terminates the register table
//   DELAY_TAG  - upper byte marking a delay entry (low byte = delay in units)
//   max_int    - elaboration-time helper for sizing the shared timer
package ov7670_pkg;

   typedef enum logic [3:0] {
      HOLD,
      SETTLE,
      FETCH,
      DECODE,
      WRITE,
      DELAY,
      NEXT,
      DONE,
      ERROR
   } state_t;

   localparam logic [15:0] TABLE_END = 16'hFFFF;
   localparam logic [7:0]  DELAY_TAG = 8'hFF;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/ov7670_timer.sv
// Loadable down-counter shared by the HOLD, SETTLE and DELAY intervals.
// Latency: load takes effect on the next edge; done is combinational from the count.
// Backpressure: none; counts every cycle it is not loaded, saturating at zero.
//
// Ports:
//   clk, reset - core clock, asynchronous active-high reset (count -> 0)
//   load       - load load_val this cycle (wins over decrement)
//   load_val   - interval length in cycles
//   done       - high in the final cycle of the interval (count <= 1)
module ov7670_timer #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic         done
);

   logic [W-1:0] count;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (count != '0) begin
         count <= count - W'(1);
      end
   end

   // A loaded value of N keeps the owning state for N cycles; 0 and 1
   // both mean "this is the only cycle".
   assign done = (count <= W'(1));

endmodule

// File: rtl/ov7670_init_sequencer.sv
// Powers up the OV7670, walks the register table in ROM and issues one SCCB write per entry.
// Latency: first sccb_req RESET_HOLD_CYCLES + SETTLE_CYCLES + 2 cycles after reset release.
// Backpressure: sccb_req is held until sccb_ack/sccb_err; a NACK is retried up to MAX_RETRIES times.
//
// Ports:
//   clk, reset             - 24 MHz core clock, asynchronous active-high reset
//   restart                - one-cycle pulse, re-runs the sequence from DONE or ERROR only
//   ov7670_pwrdn           - camera power-down (1 = powered down), high only in HOLD
//   ov7670_reset           - camera RESET pin, active low, low only in HOLD
//   rom_addr / rom_data    - synchronous table ROM, data valid one cycle after address
//   sccb_req/addr/data     - write request to the SCCB master, addr/data stable while req
//   sccb_ack / sccb_err    - one-cycle completion pulses (err wins if both)
//   start_capture          - level, high in DONE
//   busy                   - level, low only in DONE and ERROR
//   init_error             - level, high in ERROR
module ov7670_init_sequencer
   import ov7670_pkg::*;
#(
   parameter int ADDR_W            = 8,
   parameter int RESET_HOLD_CYCLES = 24000,
   parameter int SETTLE_CYCLES     = 48000,
   parameter int DELAY_UNIT_CYCLES = 24000,
   parameter int MAX_RETRIES       = 3
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              restart,
   output logic              ov7670_pwrdn,
   output logic              ov7670_reset,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [15:0]       rom_data,
   output logic              sccb_req,
   output logic [7:0]        sccb_addr,
   output logic [7:0]        sccb_data,
   input  logic              sccb_ack,
   input  logic              sccb_err,
   output logic              start_capture,
   output logic              busy,
   output logic              init_error
);

   // Timer must span the longest of the three intervals, the largest delay
   // entry being 255 units.
   localparam int DELAY_MAX = 255 * DELAY_UNIT_CYCLES;
   localparam int TMR_MAX   = max_int(DELAY_MAX, max_int(RESET_HOLD_CYCLES, SETTLE_CYCLES));
   localparam int TMR_W     = $clog2(TMR_MAX + 1);
   localparam int RETRY_W   = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;

   localparam logic [TMR_W-1:0] HOLD_FIRST =
      TMR_W'((RESET_HOLD_CYCLES > 1) ? RESET_HOLD_CYCLES - 1 : 0);
   localparam logic [TMR_W-1:0] SETTLE_LEN = TMR_W'(SETTLE_CYCLES);
   localparam logic [RETRY_W-1:0] RETRY_LIMIT = RETRY_W'(MAX_RETRIES);

   state_t              state, state_nxt;
   logic                tmr_load;
   logic [TMR_W-1:0]    tmr_val;
   logic                tmr_done;
   logic [TMR_W-1:0]    delay_len;
   logic                hold_armed;
   logic                req_gap;
   logic [RETRY_W-1:0]  retry_cnt;
   logic                latch_entry;
   logic                addr_clr;
   logic                addr_inc;
   logic                retry_inc;

   assign delay_len = TMR_W'(rom_data[7:0]) * TMR_W'(DELAY_UNIT_CYCLES);

   ov7670_timer #(
      .W (TMR_W)
   ) u_timer (
      .clk      (clk),
      .reset    (reset),
      .load     (tmr_load),
      .load_val (tmr_val),
      .done     (tmr_done)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= HOLD;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      tmr_load    = 1'b0;
      tmr_val     = '0;
      latch_entry = 1'b0;
      addr_clr    = 1'b0;
      addr_inc    = 1'b0;
      retry_inc   = 1'b0;

      case (state)
         // HOLD is entered from reset or restart with the timer idle, so its
         // first cycle loads the remaining length; later intervals are loaded
         // on the transition into their state.
         HOLD: begin
            if (!hold_armed) begin
               tmr_load = 1'b1;
               tmr_val  = HOLD_FIRST;
               if (RESET_HOLD_CYCLES <= 1) begin
                  tmr_val   = SETTLE_LEN;
                  state_nxt = SETTLE;
               end
            end else if (tmr_done) begin
               tmr_load  = 1'b1;
               tmr_val   = SETTLE_LEN;
               state_nxt = SETTLE;
            end
         end

         SETTLE: begin
            addr_clr = 1'b1;
            if (tmr_done) begin
               state_nxt = FETCH;
            end
         end

         FETCH: state_nxt = DECODE;

         DECODE: begin
            if (rom_data == TABLE_END) begin
               state_nxt = DONE;
            end else if (rom_data[15:8] == DELAY_TAG) begin
               tmr_load  = 1'b1;
               tmr_val   = delay_len;
               state_nxt = DELAY;
            end else begin
               latch_entry = 1'b1;
               state_nxt   = WRITE;
            end
         end

         // During the one-cycle gap before a retry the request is low and
         // any stray response is ignored.
         WRITE: begin
            if (!req_gap) begin
               if (sccb_err) begin
                  if (retry_cnt < RETRY_LIMIT) begin
                     retry_inc = 1'b1;
                  end else begin
                     state_nxt = ERROR;
                  end
               end else if (sccb_ack) begin
                  state_nxt = NEXT;
               end
            end
         end

         DELAY: begin
            if (tmr_done) begin
               state_nxt = NEXT;
            end
         end

         // The last ROM slot ends the table even without an end marker.
         NEXT: begin
            if (rom_addr == '1) begin
               state_nxt = DONE;
            end else begin
               addr_inc  = 1'b1;
               state_nxt = FETCH;
            end
         end

         DONE, ERROR: begin
            if (restart) begin
               state_nxt = HOLD;
            end
         end

         default: state_nxt = HOLD;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rom_addr   <= '0;
         sccb_addr  <= '0;
         sccb_data  <= '0;
         retry_cnt  <= '0;
         req_gap    <= 1'b0;
         hold_armed <= 1'b0;
      end else begin
         // Low in the first HOLD cycle after any entry, high afterwards.
         hold_armed <= (state == HOLD);
         req_gap    <= retry_inc;

         if (addr_clr) begin
            rom_addr <= '0;
         end else if (addr_inc) begin
            rom_addr <= rom_addr + ADDR_W'(1);
         end

         // sccb_addr/data are only rewritten here, so ERROR keeps the
         // failing register visible.
         if (latch_entry) begin
            sccb_addr <= rom_data[15:8];
            sccb_data <= rom_data[7:0];
            retry_cnt <= '0;
         end else if (retry_inc) begin
            retry_cnt <= retry_cnt + RETRY_W'(1);
         end
      end
   end

   // Outputs decode straight from state so reset clears them asynchronously.
   assign ov7670_pwrdn  = (state == HOLD);
   assign ov7670_reset  = (state != HOLD);
   assign sccb_req      = (state == WRITE) && !req_gap;
   assign start_capture = (state == DONE);
   assign init_error    = (state == ERROR);
   assign busy          = (state != DONE) && (state != ERROR);

endmodule

// File: tb/tb_ov7670_init_sequencer.sv
// Directed bench for ov7670_init_sequencer: power-up timing, delay entries,
// NACK retry/abort, ack+err collision, async reset, restart and table wrap.
module tb_ov7670_init_sequencer;

   localparam int AW = 2;

   logic          clk = 1'b0;
   logic          reset;
   logic          restart;
   logic          ov7670_pwrdn;
   logic          ov7670_reset;
   logic [AW-1:0] rom_addr;
   logic [15:0]   rom_data;
   logic          sccb_req;
   logic [7:0]    sccb_addr;
   logic [7:0]    sccb_data;
   logic          sccb_ack;
   logic          sccb_err;
   logic          start_capture;
   logic          busy;
   logic          init_error;

   logic [15:0]   rom_mem [4];
   int            cyc;
   int            total = 0;
   int            bad   = 0;

   ov7670_init_sequencer #(
      .ADDR_W            (AW),
      .RESET_HOLD_CYCLES (4),
      .SETTLE_CYCLES     (6),
      .DELAY_UNIT_CYCLES (3),
      .MAX_RETRIES       (3)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .restart       (restart),
      .ov7670_pwrdn  (ov7670_pwrdn),
      .ov7670_reset  (ov7670_reset),
      .rom_addr      (rom_addr),
      .rom_data      (rom_data),
      .sccb_req      (sccb_req),
      .sccb_addr     (sccb_addr),
      .sccb_data     (sccb_data),
      .sccb_ack      (sccb_ack),
      .sccb_err      (sccb_err),
      .start_capture (start_capture),
      .busy          (busy),
      .init_error    (init_error)
   );

   always #5 clk = ~clk;

   // Synchronous ROM: one cycle of read latency.
   always @(posedge clk) rom_data <= rom_mem[rom_addr];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic tick_to(input int n);
      while (cyc < n) tick();
   endtask

   task automatic wait_req(input int limit, output int at);
      at = -1;
      for (int i = 0; i < limit; i++) begin
         if (sccb_req) begin
            at = cyc;
            break;
         end
         tick();
      end
   endtask

   // kind: 0 = ack, 1 = err (NACK), 2 = ack and err together
   task automatic do_write(input string tag, input int exp_at, input logic [7:0] ea,
                           input logic [7:0] ed, input int kind);
      int at;
      wait_req(40, at);
      check({tag, "_at"}, at, exp_at);
      check({tag, "_addr"}, sccb_addr, ea);
      check({tag, "_data"}, sccb_data, ed);
      if (at >= 0) begin
         sccb_ack = (kind != 1);
         sccb_err = (kind != 0);
         tick();
         sccb_ack = 1'b0;
         sccb_err = 1'b0;
      end
   endtask

   task automatic load_rom(input logic [15:0] a, input logic [15:0] b,
                           input logic [15:0] c, input logic [15:0] d);
      rom_mem[0] = a;
      rom_mem[1] = b;
      rom_mem[2] = c;
      rom_mem[3] = d;
   endtask

   // Pulse restart; the cycle after the pulse is HOLD cycle 0.
   task automatic restart_pulse();
      restart = 1'b1;
      tick();
      restart = 1'b0;
      cyc = 0;
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_pwrdn"}, ov7670_pwrdn, 1'b1);
      check({tag, "_rstn"},  ov7670_reset, 1'b0);
      check({tag, "_req"},   sccb_req, 1'b0);
      check({tag, "_addr"},  sccb_addr, 8'h00);
      check({tag, "_data"},  sccb_data, 8'h00);
      check({tag, "_romad"}, rom_addr, 2'd0);
      check({tag, "_start"}, start_capture, 1'b0);
      check({tag, "_busy"},  busy, 1'b1);
      check({tag, "_err"},   init_error, 1'b0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      reset    = 1'b1;
      restart  = 1'b0;
      sccb_ack = 1'b0;
      sccb_err = 1'b0;
      cyc      = 0;
      load_rom(16'h1280, 16'hFFFF, 16'h0000, 16'h0000);
      #1;
      check_reset_vals("rst");
      tick();
      tick();
      reset = 1'b0;
      cyc   = 0;

      // Power-up: HOLD cycles 0..3, SETTLE 4..9, FETCH 10, DECODE 11, WRITE 12.
      tick_to(3);
      check("pu_pwrdn_c3", ov7670_pwrdn, 1'b1);
      tick();
      check("pu_pwrdn_c4", ov7670_pwrdn, 1'b0);
      check("pu_rstn_c4", ov7670_reset, 1'b1);
      do_write("pu_w", 12, 8'h12, 8'h80, 0);
      check("pu_req_drop", sccb_req, 1'b0);
      tick_to(15);
      check("pu_start_c15", start_capture, 1'b0);
      tick();
      check("pu_start_c16", start_capture, 1'b1);
      check("pu_busy_c16", busy, 1'b0);

      // Restart in DONE: start_capture drops and pwrdn returns next cycle.
      load_rom(16'hFF02, 16'h1100, 16'hFFFF, 16'h0000);
      restart_pulse();
      check("rs_start", start_capture, 1'b0);
      check("rs_pwrdn", ov7670_pwrdn, 1'b1);
      check("rs_busy", busy, 1'b1);

      // Delay entry of 2 units x 3 cycles: DELAY 12..17, request at 12+6+3.
      tick_to(15);
      check("dl_req_mid", sccb_req, 1'b0);
      check("dl_busy_mid", busy, 1'b1);
      do_write("dl_w", 21, 8'h11, 8'h00, 0);
      tick_to(25);
      check("dl_done", start_capture, 1'b1);

      // NACK twice then ACK: three requests 2 cycles apart, then DONE.
      load_rom(16'h1234, 16'hFFFF, 16'h0000, 16'h0000);
      restart_pulse();
      do_write("rt_w1", 12, 8'h12, 8'h34, 1);
      check("rt_gap", sccb_req, 1'b0);
      do_write("rt_w2", 14, 8'h12, 8'h34, 1);
      do_write("rt_w3", 16, 8'h12, 8'h34, 0);
      tick_to(20);
      check("rt_done", start_capture, 1'b1);
      check("rt_noerr", init_error, 1'b0);

      // Four NACKs exhaust the retries: ERROR with the failing address kept.
      load_rom(16'h5678, 16'hFFFF, 16'h0000, 16'h0000);
      restart_pulse();
      do_write("er_w1", 12, 8'h56, 8'h78, 1);
      do_write("er_w2", 14, 8'h56, 8'h78, 1);
      do_write("er_w3", 16, 8'h56, 8'h78, 1);
      do_write("er_w4", 18, 8'h56, 8'h78, 1);
      check("er_cyc", cyc, 19);
      check("er_flag", init_error, 1'b1);
      check("er_start", start_capture, 1'b0);
      check("er_busy", busy, 1'b0);
      check("er_addr", sccb_addr, 8'h56);
      check("er_req", sccb_req, 1'b0);

      // ack+err together counts as a NACK: it plus three more NACKs -> ERROR.
      load_rom(16'h9ABC, 16'hFFFF, 16'h0000, 16'h0000);
      restart_pulse();
      check("bo_restart_err", init_error, 1'b0);
      do_write("bo_w1", 12, 8'h9A, 8'hBC, 2);
      check("bo_gap", sccb_req, 1'b0);
      check("bo_gap_start", start_capture, 1'b0);
      do_write("bo_w2", 14, 8'h9A, 8'hBC, 1);
      do_write("bo_w3", 16, 8'h9A, 8'hBC, 1);
      do_write("bo_w4", 18, 8'h9A, 8'hBC, 1);
      check("bo_err", init_error, 1'b1);

      // Zero-length delay then a write at ROM index 1; reset mid-WRITE.
      load_rom(16'hFF00, 16'h4321, 16'hFFFF, 16'h0000);
      restart_pulse();
      tick_to(16);
      check("ar_req_pre", sccb_req, 1'b1);
      check("ar_romad_pre", rom_addr, 2'd1);
      reset = 1'b1;
      #1;
      check_reset_vals("ar");
      tick();
      reset = 1'b0;
      cyc   = 0;
      // restart outside DONE/ERROR must be ignored.
      tick_to(6);
      restart = 1'b1;
      tick();
      restart = 1'b0;
      check("ig_pwrdn", ov7670_pwrdn, 1'b0);
      check("ig_busy", busy, 1'b1);
      do_write("ar_w", 16, 8'h43, 8'h21, 0);
      tick_to(20);
      check("ar_done", start_capture, 1'b1);

      // No end marker with 4 slots: four writes, then DONE at the last slot.
      load_rom(16'h0101, 16'h0202, 16'h0303, 16'h0404);
      restart_pulse();
      do_write("nw_w0", 12, 8'h01, 8'h01, 0);
      do_write("nw_w1", 16, 8'h02, 8'h02, 0);
      do_write("nw_w2", 20, 8'h03, 8'h03, 0);
      do_write("nw_w3", 24, 8'h04, 8'h04, 0);
      tick_to(25);
      check("nw_start_c25", start_capture, 1'b0);
      tick();
      check("nw_done", start_capture, 1'b1);
      check("nw_romad", rom_addr, 2'd3);
      tick();
      tick();
      check("nw_stay_done", start_capture, 1'b1);
      check("nw_no_req", sccb_req, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
